// File: rtl/sw_alloc_vc_lock_if.sv
// ---------------------------------------------------------------------------
// sw_alloc_vc_lock_if
// Request/grant bundle between the input blocks, the switch allocator and the
// crossbar/output blocks. Input VC (i,v) occupies flat index n = i*NUM_VCS+v.
//   req_valid       P*V      input VC has a flit requesting the switch
//   req_port        P*V*PB   requested output port per input VC
//   req_tail        P*V      requesting flit is a tail (or single-flit packet)
//   credit_cnt      P*V*CW   downstream credits for the VC's output VC
//   vc_grant_r      P*V      input VC won the switch this cycle
//   out_grant_r     P        output carries a flit next cycle
//   xbar_port_sel_r P*PB     winning input port per output
//   xbar_vc_sel_r   P*VB     winning VC per input port
//   lock_r          P        output locked by a packet in flight
// master = requester/consumer side, slave = allocator side.
// ---------------------------------------------------------------------------
interface sw_alloc_vc_lock_if #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_VCS   = 2,
    parameter int CREDIT_W  = 3
);
    localparam int PB = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int VB = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    logic [NUM_PORTS*NUM_VCS-1:0]          req_valid;
    logic [NUM_PORTS*NUM_VCS*PB-1:0]       req_port;
    logic [NUM_PORTS*NUM_VCS-1:0]          req_tail;
    logic [NUM_PORTS*NUM_VCS*CREDIT_W-1:0] credit_cnt;
    logic [NUM_PORTS*NUM_VCS-1:0]          vc_grant_r;
    logic [NUM_PORTS-1:0]                  out_grant_r;
    logic [NUM_PORTS*PB-1:0]               xbar_port_sel_r;
    logic [NUM_PORTS*VB-1:0]               xbar_vc_sel_r;
    logic [NUM_PORTS-1:0]                  lock_r;

    modport master (
        output req_valid, req_port, req_tail, credit_cnt,
        input  vc_grant_r, out_grant_r, xbar_port_sel_r, xbar_vc_sel_r, lock_r
    );

    modport slave (
        input  req_valid, req_port, req_tail, credit_cnt,
        output vc_grant_r, out_grant_r, xbar_port_sel_r, xbar_vc_sel_r, lock_r
    );
endinterface

// File: rtl/sw_alloc_vc_lock.sv
// ---------------------------------------------------------------------------
// sw_alloc_vc_lock
// Separable input-first switch allocator: per-input V:1 round-robin, then
// per-output P:1 round-robin over the input winners. Pointers advance only on
// a full success. Optional wormhole locking holds an output (and the owning
// input's VC choice) from a head grant until the tail grant. VCs that keep
// losing while eligible escalate after STARVE_LIM cycles and beat
// non-escalated requesters at both stages.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   sa   sw_alloc_vc_lock_if.slave (requests in, registered grants/selects out)
// ---------------------------------------------------------------------------
module sw_alloc_vc_lock #(
    parameter int NUM_PORTS  = 5,
    parameter int NUM_VCS    = 2,
    parameter int CREDIT_W   = 3,
    parameter int LOCK_EN    = 1,
    parameter int STARVE_LIM = 15
) (
    input  logic              clk,
    input  logic              rst,
    sw_alloc_vc_lock_if.slave sa
);
    localparam int P    = NUM_PORTS;
    localparam int V    = NUM_VCS;
    localparam int N    = P * V;
    localparam int PB   = (P > 1) ? $clog2(P) : 1;
    localparam int VB   = (V > 1) ? $clog2(V) : 1;
    localparam int CNTW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam int MAXN = (P > V) ? P : V;

    logic [N-1:0]    vc_grant_q, vc_grant_d;
    logic [P-1:0]    out_grant_q, out_grant_d;
    logic [PB-1:0]   port_sel_q [P];
    logic [PB-1:0]   port_sel_d [P];
    logic [VB-1:0]   vc_sel_q [P];
    logic [VB-1:0]   vc_sel_d [P];
    logic [VB-1:0]   in_ptr_q [P];
    logic [VB-1:0]   in_ptr_d [P];
    logic [PB-1:0]   out_ptr_q [P];
    logic [PB-1:0]   out_ptr_d [P];
    logic [P-1:0]    lock_q, lock_d;
    logic [PB-1:0]   own_port_q [P];
    logic [PB-1:0]   own_port_d [P];
    logic [VB-1:0]   own_vc_q [P];
    logic [VB-1:0]   own_vc_d [P];
    logic [P-1:0]    in_lock_q, in_lock_d;
    logic [VB-1:0]   in_lock_vc_q [P];
    logic [VB-1:0]   in_lock_vc_d [P];
    logic [CNTW-1:0] starve_q [N];
    logic [CNTW-1:0] starve_d [N];

    logic [N-1:0]    elig;
    logic [N-1:0]    esc;
    logic [P-1:0]    s1_vld;
    logic [VB-1:0]   s1_vc [P];
    logic [P-1:0]    s2_vld;
    logic [PB-1:0]   s2_port [P];

    // Lowest candidate at or above ptr; if none, wrap to the lowest candidate.
    function automatic int rr_pick(input logic [MAXN-1:0] cand, input int ptr);
        logic [MAXN-1:0] hi;
        int pick;
        pick = 0;
        for (int k = 0; k < MAXN; k++) hi[k] = cand[k] && (k >= ptr);
        for (int k = MAXN - 1; k >= 0; k--) if (cand[k]) pick = k;
        if (|hi) begin
            for (int k = MAXN - 1; k >= 0; k--) if (hi[k]) pick = k;
        end
        return pick;
    endfunction

    // Escalated candidates form a higher class; round-robin within the class.
    function automatic int class_pick(input logic [MAXN-1:0] cand,
                                      input logic [MAXN-1:0] cesc,
                                      input int ptr);
        if (|(cand & cesc)) return rr_pick(cand & cesc, ptr);
        return rr_pick(cand, ptr);
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        if (c >= CNTW'(STARVE_LIM)) return CNTW'(STARVE_LIM);
        return c + CNTW'(1);
    endfunction

    // A credit count of 1 is spent by last cycle's grant if that grant is not
    // yet reflected in credit_cnt, hence the vc_grant_q qualifier.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            elig[n] = sa.req_valid[n]
                && (sa.req_port[n*PB +: PB] != PB'(n / V))
                && ((sa.credit_cnt[n*CREDIT_W +: CREDIT_W] > CREDIT_W'(1))
                    || ((sa.credit_cnt[n*CREDIT_W +: CREDIT_W] == CREDIT_W'(1))
                        && !vc_grant_q[n]));
            esc[n] = (STARVE_LIM != 0) && (starve_q[n] == CNTW'(STARVE_LIM));
        end
    end

    // Stage 1: per input port, a locked input only offers its locking VC.
    always_comb begin
        logic [MAXN-1:0] cand;
        logic [MAXN-1:0] cesc;
        for (int i = 0; i < P; i++) begin
            cand = '0;
            cesc = '0;
            for (int v = 0; v < V; v++) begin
                cand[v] = elig[i*V+v] && (!in_lock_q[i] || (in_lock_vc_q[i] == VB'(v)));
                cesc[v] = esc[i*V+v];
            end
            s1_vld[i] = |cand;
            s1_vc[i]  = VB'(class_pick(cand, cesc, int'(in_ptr_q[i])));
        end
    end

    // Stage 2: per output port, a locked output only accepts its owner.
    always_comb begin
        logic [MAXN-1:0] cand;
        logic [MAXN-1:0] cesc;
        int n;
        n = 0;
        for (int o = 0; o < P; o++) begin
            cand = '0;
            cesc = '0;
            for (int i = 0; i < P; i++) begin
                n = i * V + int'(s1_vc[i]);
                cand[i] = s1_vld[i] && (sa.req_port[n*PB +: PB] == PB'(o))
                    && (!lock_q[o] || ((own_port_q[o] == PB'(i)) && (own_vc_q[o] == s1_vc[i])));
                cesc[i] = esc[n];
            end
            s2_vld[o]  = |cand;
            s2_port[o] = PB'(class_pick(cand, cesc, int'(out_ptr_q[o])));
        end
    end

    // Commit successes: grants, selects, pointer moves, lock and starvation.
    always_comb begin
        int i;
        int v;
        i = 0;
        v = 0;
        vc_grant_d  = '0;
        out_grant_d = s2_vld;
        lock_d      = lock_q;
        in_lock_d   = in_lock_q;
        for (int k = 0; k < P; k++) begin
            port_sel_d[k]   = port_sel_q[k];
            vc_sel_d[k]     = vc_sel_q[k];
            in_ptr_d[k]     = in_ptr_q[k];
            out_ptr_d[k]    = out_ptr_q[k];
            own_port_d[k]   = own_port_q[k];
            own_vc_d[k]     = own_vc_q[k];
            in_lock_vc_d[k] = in_lock_vc_q[k];
        end
        for (int o = 0; o < P; o++) begin
            if (s2_vld[o]) begin
                i = int'(s2_port[o]);
                v = int'(s1_vc[i]);
                vc_grant_d[i*V+v] = 1'b1;
                port_sel_d[o]     = s2_port[o];
                vc_sel_d[i]       = s1_vc[i];
                in_ptr_d[i]       = VB'((v + 1) % V);
                out_ptr_d[o]      = PB'((i + 1) % P);
                if (LOCK_EN != 0) begin
                    // Head of a multi-flit packet takes the lock; its tail releases it.
                    if (!lock_q[o] && !sa.req_tail[i*V+v]) begin
                        lock_d[o]       = 1'b1;
                        own_port_d[o]   = s2_port[o];
                        own_vc_d[o]     = s1_vc[i];
                        in_lock_d[i]    = 1'b1;
                        in_lock_vc_d[i] = s1_vc[i];
                    end else if (lock_q[o] && sa.req_tail[i*V+v]) begin
                        lock_d[o]    = 1'b0;
                        in_lock_d[i] = 1'b0;
                    end
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            if (!sa.req_valid[n] || vc_grant_d[n]) starve_d[n] = '0;
            else if (elig[n])                      starve_d[n] = sat_inc(starve_q[n]);
            else                                   starve_d[n] = starve_q[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vc_grant_q  <= '0;
            out_grant_q <= '0;
            lock_q      <= '0;
            in_lock_q   <= '0;
            for (int k = 0; k < P; k++) begin
                port_sel_q[k]   <= '0;
                vc_sel_q[k]     <= '0;
                in_ptr_q[k]     <= '0;
                out_ptr_q[k]    <= '0;
                own_port_q[k]   <= '0;
                own_vc_q[k]     <= '0;
                in_lock_vc_q[k] <= '0;
            end
            for (int n = 0; n < N; n++) starve_q[n] <= '0;
        end else begin
            vc_grant_q  <= vc_grant_d;
            out_grant_q <= out_grant_d;
            lock_q      <= lock_d;
            in_lock_q   <= in_lock_d;
            for (int k = 0; k < P; k++) begin
                port_sel_q[k]   <= port_sel_d[k];
                vc_sel_q[k]     <= vc_sel_d[k];
                in_ptr_q[k]     <= in_ptr_d[k];
                out_ptr_q[k]    <= out_ptr_d[k];
                own_port_q[k]   <= own_port_d[k];
                own_vc_q[k]     <= own_vc_d[k];
                in_lock_vc_q[k] <= in_lock_vc_d[k];
            end
            for (int n = 0; n < N; n++) starve_q[n] <= starve_d[n];
        end
    end

    assign sa.vc_grant_r  = vc_grant_q;
    assign sa.out_grant_r = out_grant_q;
    assign sa.lock_r      = lock_q;

    always_comb begin
        sa.xbar_port_sel_r = '0;
        sa.xbar_vc_sel_r   = '0;
        for (int k = 0; k < P; k++) begin
            sa.xbar_port_sel_r[k*PB +: PB] = port_sel_q[k];
            sa.xbar_vc_sel_r[k*VB +: VB]   = vc_sel_q[k];
        end
    end
endmodule

// File: tb/tb_sw_alloc_vc_lock.sv
// ---------------------------------------------------------------------------
// tb_sw_alloc_vc_lock
// Directed scenarios followed by randomized packet traffic. Every cycle the
// registered outputs are compared with a behavioural model of the allocation
// rules (scan from pointer, escalated class first, lock ownership per output).
// ---------------------------------------------------------------------------
module tb_sw_alloc_vc_lock;
    localparam int P    = 5;
    localparam int V    = 2;
    localparam int CW   = 3;
    localparam int SLIM = 2;
    localparam int PB   = 3;
    localparam int VB   = 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sw_alloc_vc_lock_if #(.NUM_PORTS(P), .NUM_VCS(V), .CREDIT_W(CW)) bus ();

    sw_alloc_vc_lock #(
        .NUM_PORTS(P), .NUM_VCS(V), .CREDIT_W(CW), .LOCK_EN(1), .STARVE_LIM(SLIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sa (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus
    bit s_valid [P][V];
    int s_dest  [P][V];
    bit s_tail  [P][V];
    int s_cred  [P][V];
    int rem     [P][V];
    bit started [P][V];

    // model state and expected outputs
    int m_in_ptr [P];
    int m_out_ptr[P];
    int m_cnt    [P][V];
    int m_owner  [P];        // -1 when unlocked, else i*V+v
    bit m_prev   [P][V];
    bit e_gnt    [P][V];
    bit e_og     [P];
    int e_psel   [P];
    int e_vsel   [P];
    bit e_lock   [P];

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < P; i++)
            for (int v = 0; v < V; v++) begin
                s_valid[i][v] = 0; s_dest[i][v] = 0; s_tail[i][v] = 0; s_cred[i][v] = 0;
                rem[i][v] = 0; started[i][v] = 0;
            end
    endtask

    task automatic set_vc(input int i, input int v, input bit vl, input int d,
                          input bit t, input int c);
        s_valid[i][v] = vl; s_dest[i][v] = d; s_tail[i][v] = t; s_cred[i][v] = c;
    endtask

    task automatic apply();
        logic [P*V-1:0]    rv;
        logic [P*V-1:0]    rt;
        logic [P*V*PB-1:0] rp;
        logic [P*V*CW-1:0] rc;
        for (int i = 0; i < P; i++)
            for (int v = 0; v < V; v++) begin
                rv[i*V+v] = s_valid[i][v];
                rt[i*V+v] = s_tail[i][v];
                rp[(i*V+v)*PB +: PB] = PB'(s_dest[i][v]);
                rc[(i*V+v)*CW +: CW] = CW'(s_cred[i][v]);
            end
        bus.req_valid  = rv;
        bus.req_tail   = rt;
        bus.req_port   = rp;
        bus.credit_cnt = rc;
    endtask

    task automatic model_step(input bit r);
        bit elig[P][V];
        bit esc [P][V];
        int w1[P];
        int w2[P];
        int lv;
        int i;
        int v;
        if (r) begin
            for (int k = 0; k < P; k++) begin
                m_in_ptr[k] = 0; m_out_ptr[k] = 0; m_owner[k] = -1;
                e_og[k] = 0; e_psel[k] = 0; e_vsel[k] = 0; e_lock[k] = 0;
                for (int j = 0; j < V; j++) begin
                    m_cnt[k][j] = 0; m_prev[k][j] = 0; e_gnt[k][j] = 0;
                end
            end
            return;
        end
        for (int a = 0; a < P; a++)
            for (int b = 0; b < V; b++) begin
                elig[a][b] = s_valid[a][b] && (s_dest[a][b] != a) &&
                             (s_cred[a][b] > 1 || (s_cred[a][b] == 1 && !m_prev[a][b]));
                esc[a][b]  = (SLIM != 0) && (m_cnt[a][b] == SLIM);
            end
        for (int a = 0; a < P; a++) begin
            lv = -1;
            for (int o = 0; o < P; o++)
                if (m_owner[o] >= 0 && m_owner[o] / V == a) lv = m_owner[o] % V;
            w1[a] = -1;
            for (int pass = 0; pass < 2; pass++)
                for (int k = 0; k < V; k++) begin
                    v = (m_in_ptr[a] + k) % V;
                    if (w1[a] < 0 && elig[a][v] && (lv < 0 || lv == v) && (pass == 1 || esc[a][v]))
                        w1[a] = v;
                end
        end
        for (int o = 0; o < P; o++) begin
            w2[o] = -1;
            for (int pass = 0; pass < 2; pass++)
                for (int k = 0; k < P; k++) begin
                    i = (m_out_ptr[o] + k) % P;
                    if (w2[o] < 0 && w1[i] >= 0 && s_dest[i][w1[i]] == o &&
                        (m_owner[o] < 0 || m_owner[o] == i * V + w1[i]) &&
                        (pass == 1 || esc[i][w1[i]]))
                        w2[o] = i;
                end
        end
        for (int a = 0; a < P; a++) begin
            e_og[a] = 0;
            for (int b = 0; b < V; b++) e_gnt[a][b] = 0;
        end
        for (int o = 0; o < P; o++) begin
            if (w2[o] >= 0) begin
                i = w2[o];
                v = w1[i];
                e_gnt[i][v] = 1; e_og[o] = 1; e_psel[o] = i; e_vsel[i] = v;
                m_in_ptr[i] = (v + 1) % V;
                m_out_ptr[o] = (i + 1) % P;
                if (m_owner[o] < 0 && !s_tail[i][v]) m_owner[o] = i * V + v;
                else if (m_owner[o] >= 0 && s_tail[i][v]) m_owner[o] = -1;
            end
        end
        for (int a = 0; a < P; a++)
            for (int b = 0; b < V; b++) begin
                if (!s_valid[a][b] || e_gnt[a][b]) m_cnt[a][b] = 0;
                else if (elig[a][b]) m_cnt[a][b] = (m_cnt[a][b] < SLIM) ? m_cnt[a][b] + 1 : SLIM;
                m_prev[a][b] = e_gnt[a][b];
            end
        for (int o = 0; o < P; o++) e_lock[o] = (m_owner[o] >= 0);
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic step();
        logic [P*V-1:0]  eg;
        logic [P-1:0]    eo;
        logic [P-1:0]    el;
        logic [P*PB-1:0] eps;
        logic [P*VB-1:0] evs;
        apply();
        model_step(rst);
        @(posedge clk);
        #1;
        for (int i = 0; i < P; i++) begin
            for (int v = 0; v < V; v++) eg[i*V+v] = e_gnt[i][v];
            eo[i] = e_og[i];
            el[i] = e_lock[i];
            eps[i*PB +: PB] = PB'(e_psel[i]);
            evs[i*VB +: VB] = VB'(e_vsel[i]);
        end
        chk("vc_grant_r",      int'(bus.vc_grant_r),      int'(eg));
        chk("out_grant_r",     int'(bus.out_grant_r),     int'(eo));
        chk("lock_r",          int'(bus.lock_r),          int'(el));
        chk("xbar_port_sel_r", int'(bus.xbar_port_sel_r), int'(eps));
        chk("xbar_vc_sel_r",   int'(bus.xbar_vc_sel_r),   int'(evs));
    endtask

    initial begin
        int flits;
        int got;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        clear_stim();
        step();
        chk("rst_vc_grant", int'(bus.vc_grant_r), 0);
        chk("rst_lock", int'(bus.lock_r), 0);
        step();
        rst = 1'b0;
        repeat (6) step();

        // three inputs, VC0, all to output 4
        for (int a = 0; a < 3; a++) set_vc(a, 0, 1, 4, 1, 4);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("psel4_seq", int'(bus.xbar_port_sel_r[4*PB +: PB]), k % 3);
            chk("ogrant4", int'(bus.out_grant_r[4]), 1);
        end

        // input 1 both VCs (input 1 pointer already at VC1 from the last phase)
        clear_stim();
        step();
        set_vc(1, 0, 1, 2, 1, 4);
        set_vc(1, 1, 1, 3, 1, 4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("vcsel1_alt", int'(bus.xbar_vc_sel_r[1*VB +: VB]), (k + 1) % 2);
            chk("port1_one_vc", $countones(bus.vc_grant_r[3:2]), 1);
        end

        // credit boundary and u-turn on input 3 VC1
        clear_stim();
        set_vc(3, 1, 1, 0, 1, 1);
        step();
        chk("cr1_first", int'(bus.vc_grant_r[7]), 1);
        step();
        chk("cr1_second", int'(bus.vc_grant_r[7]), 0);
        set_vc(3, 1, 1, 0, 1, 0);
        repeat (2) begin step(); chk("cr0", int'(bus.vc_grant_r[7]), 0); end
        set_vc(3, 1, 1, 3, 1, 4);
        repeat (3) begin step(); chk("uturn", int'(bus.vc_grant_r[7]), 0); end

        // wormhole lock: 4-flit packet 0->1 against single flit 2->1
        clear_stim();
        step();
        set_vc(2, 0, 1, 1, 1, 4);
        set_vc(0, 0, 1, 1, 0, 4);
        flits = 4;
        for (int k = 0; k < 5; k++) begin
            s_valid[0][0] = (flits > 0);
            s_tail[0][0]  = (flits == 1);
            step();
            if (e_gnt[0][0]) flits--;
            if (k < 4) chk("in2_blocked", int'(bus.vc_grant_r[4]), 0);
            else       chk("in2_after_tail", int'(bus.vc_grant_r[4]), 1);
            if (k == 0) chk("lock_after_head", int'(bus.lock_r[1]), 1);
            if (k == 3) chk("unlock_after_tail", int'(bus.lock_r[1]), 0);
        end

        // reset mid-packet drops the lock
        clear_stim();
        set_vc(0, 0, 1, 1, 0, 4);
        step();
        chk("lock_new_head", int'(bus.lock_r[1]), 1);
        step();
        rst = 1'b1;
        step();
        chk("lock_rst", int'(bus.lock_r[1]), 0);
        rst = 1'b0;
        clear_stim();
        step();

        // starvation: input 4 held off by credit, then released
        set_vc(0, 0, 1, 1, 1, 4);
        set_vc(2, 0, 1, 1, 1, 4);
        set_vc(3, 0, 1, 1, 1, 4);
        set_vc(4, 0, 1, 1, 1, 0);
        repeat (2) step();
        s_cred[4][0] = 4;
        got = 0;
        for (int k = 0; k < 6; k++) begin
            if (got == 0) begin
                step();
                if (bus.vc_grant_r[8]) got = 1;
            end
        end
        chk("starved_in4_granted", got, 1);

        // randomized packet traffic
        clear_stim();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 1500 || cyc == 1501 || $urandom_range(0, 399) == 0);
            for (int i = 0; i < P; i++)
                for (int v = 0; v < V; v++) begin
                    if (rem[i][v] == 0 && $urandom_range(0, 3) == 0) begin
                        rem[i][v] = $urandom_range(1, 4);
                        s_dest[i][v] = $urandom_range(0, P - 1);
                        started[i][v] = 0;
                    end else if (rem[i][v] > 0 && !started[i][v] && $urandom_range(0, 31) == 0) begin
                        rem[i][v] = 0;
                    end
                    s_valid[i][v] = (rem[i][v] > 0) && ($urandom_range(0, 7) != 0);
                    s_tail[i][v]  = (rem[i][v] == 1);
                    s_cred[i][v]  = $urandom_range(0, 5);
                end
            step();
            for (int i = 0; i < P; i++)
                for (int v = 0; v < V; v++)
                    if (e_gnt[i][v] && rem[i][v] > 0) begin
                        rem[i][v]--;
                        started[i][v] = (rem[i][v] > 0);
                    end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
